fm_demod: RTL and testbench

Quadrature FM discriminator stage. It sits directly downstream of the complex channel FIR and pops one filtered I/Q sample pair from its two output FIFOs. Each output is the phase difference to the previous sample, computed with the fixed-point `qarctan` approximation, scaled by the demodulator gain and pushed as one 32-bit audio-rate word to a single output FIFO. It is iterative and not pipelined: one sample per 37 cycles at best.

---
 rtl/fm_demod.sv | 225 ++++++++++++++++++++++
 tb/tb_fm_demod.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_demod.sv
// fm_demod: quadrature FM discriminator.
// Pops one I/Q pair from two first-word-fall-through FIFOs. Each popped pair is
// multiplied against the previous pair and turned into a phase step with the
// qarctan approximation. The step is scaled by GAIN and pushed to one output FIFO.
// The datapath is iterative: 1 read, 1 mult, 1 setup, 32 divide, 1 angle and
// 1 write cycle, so one sample per 37 cycles at best.
// Optional build macro FM_DEMOD_SAT_EN: clamps the result to signed 16 bits
// before it is registered.
//
// Handshakes: real_rd_en/imag_rd_en pulse together only in S_READ when both
// FIFOs are non-empty, and each pulse pops one word. out_wr_en pulses only in
// S_WRITE when out_full is low, and each pulse pushes demod_out. Both strobes
// are combinational from registered state and are held low during reset.
module fm_demod #(
    parameter int BITS  = 10,
    parameter int QUAD1 = 804,
    parameter int QUAD3 = 2412,
    parameter int GAIN  = 758
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] real_in,
    input  logic [31:0] imag_in,
    input  logic        real_empty,
    input  logic        imag_empty,
    output logic        real_rd_en,
    output logic        imag_rd_en,
    output logic [31:0] demod_out,
    output logic        out_wr_en,
    input  logic        out_full
);

    typedef enum logic [2:0] {
        S_READ  = 3'd0,
        S_MULT  = 3'd1,
        S_SETUP = 3'd2,
        S_DIV   = 3'd3,
        S_ANGLE = 3'd4,
        S_WRITE = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic signed [31:0] cur_re_q, cur_re_d;
    logic signed [31:0] cur_im_q, cur_im_d;
    logic signed [31:0] prev_re_q, prev_re_d;
    logic signed [31:0] prev_im_q, prev_im_d;
    logic signed [31:0] r_q, r_d;
    logic signed [31:0] i_q, i_d;
    logic signed [31:0] base_q, base_d;
    logic [31:0]        div_rem_q, div_rem_d;
    logic [31:0]        div_quo_q, div_quo_d;
    logic [31:0]        div_den_q, div_den_d;
    logic [4:0]         div_cnt_q, div_cnt_d;
    logic               div_neg_q, div_neg_d;
    logic signed [31:0] demod_q, demod_d;

    // Scratch values for the current state's arithmetic.
    logic signed [31:0] abs_y;
    logic signed [31:0] num;
    logic signed [31:0] den;
    logic [31:0]        dividend;
    logic [32:0]        rem_shift;
    logic signed [31:0] quo_s;
    logic signed [31:0] angle;
    logic signed [31:0] res;

    assign demod_out = demod_q;

    // State register and datapath registers, asynchronously cleared.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_READ;
            cur_re_q  <= '0;
            cur_im_q  <= '0;
            prev_re_q <= '0;
            prev_im_q <= '0;
            r_q       <= '0;
            i_q       <= '0;
            base_q    <= '0;
            div_rem_q <= '0;
            div_quo_q <= '0;
            div_den_q <= '0;
            div_cnt_q <= '0;
            div_neg_q <= 1'b0;
            demod_q   <= '0;
        end else begin
            state_q   <= state_d;
            cur_re_q  <= cur_re_d;
            cur_im_q  <= cur_im_d;
            prev_re_q <= prev_re_d;
            prev_im_q <= prev_im_d;
            r_q       <= r_d;
            i_q       <= i_d;
            base_q    <= base_d;
            div_rem_q <= div_rem_d;
            div_quo_q <= div_quo_d;
            div_den_q <= div_den_d;
            div_cnt_q <= div_cnt_d;
            div_neg_q <= div_neg_d;
            demod_q   <= demod_d;
        end
    end

    // Next-state, datapath update and strobe generation for each step.
    always_comb begin
        state_d    = state_q;
        cur_re_d   = cur_re_q;
        cur_im_d   = cur_im_q;
        prev_re_d  = prev_re_q;
        prev_im_d  = prev_im_q;
        r_d        = r_q;
        i_d        = i_q;
        base_d     = base_q;
        div_rem_d  = div_rem_q;
        div_quo_d  = div_quo_q;
        div_den_d  = div_den_q;
        div_cnt_d  = div_cnt_q;
        div_neg_d  = div_neg_q;
        demod_d    = demod_q;
        real_rd_en = 1'b0;
        imag_rd_en = 1'b0;
        out_wr_en  = 1'b0;
        abs_y      = '0;
        num        = '0;
        den        = '0;
        dividend   = '0;
        rem_shift  = '0;
        quo_s      = '0;
        angle      = '0;
        res        = '0;

        case (state_q)
            S_READ: begin
                if (!reset && !real_empty && !imag_empty) begin
                    real_rd_en = 1'b1;
                    imag_rd_en = 1'b1;
                    cur_re_d   = $signed(real_in);
                    cur_im_d   = $signed(imag_in);
                    state_d    = S_MULT;
                end
            end

            S_MULT: begin
                // Conjugate product prev* x cur; each term dequantised separately.
                r_d = 32'((64'(prev_re_q) * 64'(cur_re_q)) >>> BITS)
                    + 32'((64'(prev_im_q) * 64'(cur_im_q)) >>> BITS);
                i_d = 32'((64'(prev_re_q) * 64'(cur_im_q)) >>> BITS)
                    - 32'((64'(prev_im_q) * 64'(cur_re_q)) >>> BITS);
                prev_re_d = cur_re_q;
                prev_im_d = cur_im_q;
                state_d   = S_SETUP;
            end

            S_SETUP: begin
                // The +1 keeps the denominator non-zero for a zero vector.
                abs_y = ((i_q < 0) ? -i_q : i_q) + 32'sd1;
                if (!r_q[31]) begin
                    num    = 32'((r_q - abs_y) << BITS);
                    den    = r_q + abs_y;
                    base_d = QUAD1;
                end else begin
                    num    = 32'((r_q + abs_y) << BITS);
                    den    = abs_y - r_q;
                    base_d = QUAD3;
                end
                dividend  = num[31] ? 32'(-num) : num;
                div_neg_d = num[31];
                div_quo_d = dividend;
                div_rem_d = '0;
                div_den_d = den;
                div_cnt_d = '0;
                state_d   = S_DIV;
            end

            S_DIV: begin
                // The quotient register holds the dividend bits not yet shifted
                // out at its top. Quotient bits fill in at its bottom.
                rem_shift = {div_rem_q, div_quo_q[31]};
                if (rem_shift >= {1'b0, div_den_q}) begin
                    div_rem_d = 32'(rem_shift - {1'b0, div_den_q});
                    div_quo_d = {div_quo_q[30:0], 1'b1};
                end else begin
                    div_rem_d = rem_shift[31:0];
                    div_quo_d = {div_quo_q[30:0], 1'b0};
                end
                div_cnt_d = div_cnt_q + 5'd1;
                if (div_cnt_q == 5'd31) begin
                    state_d = S_ANGLE;
                end
            end

            S_ANGLE: begin
                quo_s = div_neg_q ? -$signed(div_quo_q) : $signed(div_quo_q);
                angle = base_q - 32'((64'(QUAD1) * 64'(quo_s)) >>> BITS);
                if (i_q < 0) begin
                    angle = -angle;
                end
                res = 32'((64'(GAIN) * 64'(angle)) >>> BITS);
`ifdef FM_DEMOD_SAT_EN
                if (res > 32'sd32767) begin
                    res = 32'sd32767;
                end else if (res < -32'sd32768) begin
                    res = -32'sd32768;
                end
`else
                res = res;
`endif
                demod_d = res;
                state_d = S_WRITE;
            end

            S_WRITE: begin
                if (!out_full) begin
                    out_wr_en = 1'b1;
                    state_d   = S_READ;
                end
            end

            default: begin
                state_d = S_READ;
            end
        endcase
    end

endmodule

// File: tb/tb_fm_demod.sv
// tb_fm_demod: directed bench for fm_demod with hand-computed expected outputs.
// A second instance runs with GAIN = 2^20 to observe the large-result path.
`timescale 1ns/1ps
module tb_fm_demod;

    logic        clock;
    logic        reset;
    logic [31:0] real_in;
    logic [31:0] imag_in;
    logic        real_empty;
    logic        imag_empty;
    logic        out_full;
    logic        real_rd_en;
    logic        imag_rd_en;
    logic [31:0] demod_out;
    logic        out_wr_en;
    logic        g_real_rd_en;
    logic        g_imag_rd_en;
    logic [31:0] g_demod_out;
    logic        g_out_wr_en;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

`ifdef FM_DEMOD_SAT_EN
    localparam int EXP_G_FIRST = 32767;
`else
    localparam int EXP_G_FIRST = 1646592;
`endif

    fm_demod dut (
        .clock      (clock),
        .reset      (reset),
        .real_in    (real_in),
        .imag_in    (imag_in),
        .real_empty (real_empty),
        .imag_empty (imag_empty),
        .real_rd_en (real_rd_en),
        .imag_rd_en (imag_rd_en),
        .demod_out  (demod_out),
        .out_wr_en  (out_wr_en),
        .out_full   (out_full)
    );

    fm_demod #(.GAIN(1 << 20)) dut_g (
        .clock      (clock),
        .reset      (reset),
        .real_in    (real_in),
        .imag_in    (imag_in),
        .real_empty (real_empty),
        .imag_empty (imag_empty),
        .real_rd_en (g_real_rd_en),
        .imag_rd_en (g_imag_rd_en),
        .demod_out  (g_demod_out),
        .out_wr_en  (g_out_wr_en),
        .out_full   (out_full)
    );

    // Clock and cycle counter.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Offer one I/Q pair, then watch for the push. lat is the cycle distance
    // from the pop cycle to the push cycle (-1 if no pop or no push seen).
    // out_full is held high for `stall` cycles once S_WRITE is reached.
    task automatic drive_sample(input logic [31:0] re, input logic [31:0] im,
                                input int stall, output int lat, output int got,
                                output int got_g, output int wr_cnt,
                                output int pops, output int bad_wr);
        int k;
        int t;
        lat    = -1;
        got    = 0;
        got_g  = 0;
        wr_cnt = 0;
        pops   = 0;
        bad_wr = 0;
        @(negedge clock);
        real_in    = re;
        imag_in    = im;
        out_full   = (stall > 0);
        real_empty = 1'b0;
        imag_empty = 1'b0;
        #1;
        t = 0;
        while (!real_rd_en && t < 100) begin
            @(negedge clock);
            #1;
            t++;
        end
        if (!real_rd_en) begin
            real_empty = 1'b1;
            imag_empty = 1'b1;
            out_full   = 1'b0;
            return;
        end
        k = cyc;
        @(posedge clock);
        #1;
        real_empty = 1'b1;
        imag_empty = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clock);
            if (stall > 0 && (cyc - k) >= 36 + stall) out_full = 1'b0;
            #1;
            if (real_rd_en || imag_rd_en) pops++;
            if (out_wr_en && out_full) bad_wr++;
            if (out_wr_en) begin
                wr_cnt++;
                if (lat < 0) begin
                    lat   = cyc - k;
                    got   = $signed(demod_out);
                    got_g = $signed(g_demod_out);
                end
            end
        end
        out_full = 1'b0;
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        real_in    = 32'd1024;
        imag_in    = 32'd0;
        real_empty = 1'b0;
        imag_empty = 1'b0;
        out_full   = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if (real_rd_en !== 1'b0 || imag_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_rd_en got=%b/%b exp=0/0", real_rd_en, imag_rd_en);
        end
        checks++;
        if (out_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_wr_en got=%b exp=0", out_wr_en);
        end
        checks++;
        if (demod_out !== 32'd0) begin
            failures++;
            $display("FAIL reset_demod_out got=%0d exp=0", $signed(demod_out));
        end
        real_empty = 1'b1;
        imag_empty = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_partial_empty;
        int seen;
        seen = 0;
        real_empty = 1'b1;
        imag_empty = 1'b0;
        repeat (4) begin
            @(negedge clock);
            #1;
            if (real_rd_en || imag_rd_en) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL rd_real_empty got=%0d exp=0", seen);
        end
        seen = 0;
        real_empty = 1'b0;
        imag_empty = 1'b1;
        repeat (4) begin
            @(negedge clock);
            #1;
            if (real_rd_en || imag_rd_en) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL rd_imag_empty got=%0d exp=0", seen);
        end
        real_empty = 1'b1;
        imag_empty = 1'b1;
    endtask

    task automatic test_first_sample;
        int lat, got, got_g, wr_cnt, pops, bad_wr;
        drive_sample(32'd1024, 32'd0, 0, lat, got, got_g, wr_cnt, pops, bad_wr);
        checks++;
        if (lat != 36) begin
            failures++;
            $display("FAIL first_latency got=%0d exp=36", lat);
        end
        checks++;
        if (got != 1190) begin
            failures++;
            $display("FAIL first_value got=%0d exp=1190", got);
        end
        checks++;
        if (got_g != EXP_G_FIRST) begin
            failures++;
            $display("FAIL first_big_gain got=%0d exp=%0d", got_g, EXP_G_FIRST);
        end
        checks++;
        if (wr_cnt != 1) begin
            failures++;
            $display("FAIL first_wr_count got=%0d exp=1", wr_cnt);
        end
    endtask

    task automatic test_phase_steps;
        int lat, got, got_g, wr_cnt, pops, bad_wr;
        // prev (1024,0), cur (1024,0): zero phase step.
        drive_sample(32'd1024, 32'd0, 0, lat, got, got_g, wr_cnt, pops, bad_wr);
        checks++;
        if (got != 1 || lat != 36) begin
            failures++;
            $display("FAIL zero_step got=%0d lat=%0d exp=1 lat=36", got, lat);
        end
        // prev (1024,0), cur (0,-1024): negative quarter turn, r >= 0 branch.
        drive_sample(32'd0, 32'hFFFF_FC00, 0, lat, got, got_g, wr_cnt, pops, bad_wr);
        checks++;
        if (got != -1191 || lat != 36) begin
            failures++;
            $display("FAIL neg_step got=%0d lat=%0d exp=-1191 lat=36", got, lat);
        end
        // prev (0,-1024), cur (1024,0): positive quarter turn.
        drive_sample(32'd1024, 32'd0, 0, lat, got, got_g, wr_cnt, pops, bad_wr);
        checks++;
        if (got != 1190 || lat != 36) begin
            failures++;
            $display("FAIL pos_step got=%0d lat=%0d exp=1190 lat=36", got, lat);
        end
        // prev (1024,0), cur (-1024,0): half turn, r < 0 branch.
        drive_sample(32'hFFFF_FC00, 32'd0, 0, lat, got, got_g, wr_cnt, pops, bad_wr);
        checks++;
        if (got != 2379 || lat != 36) begin
            failures++;
            $display("FAIL half_turn got=%0d lat=%0d exp=2379 lat=36", got, lat);
        end
    endtask

    task automatic test_backpressure;
        int lat, got, got_g, wr_cnt, pops, bad_wr;
        // prev (-1024,0), cur (1024,0): half turn again, stalled 10 cycles.
        drive_sample(32'd1024, 32'd0, 10, lat, got, got_g, wr_cnt, pops, bad_wr);
        checks++;
        if (lat != 46) begin
            failures++;
            $display("FAIL bp_latency got=%0d exp=46", lat);
        end
        checks++;
        if (bad_wr != 0) begin
            failures++;
            $display("FAIL bp_wr_while_full got=%0d exp=0", bad_wr);
        end
        checks++;
        if (wr_cnt != 1) begin
            failures++;
            $display("FAIL bp_wr_count got=%0d exp=1", wr_cnt);
        end
        checks++;
        if (pops != 0) begin
            failures++;
            $display("FAIL bp_extra_pops got=%0d exp=0", pops);
        end
        checks++;
        if (got != 2379) begin
            failures++;
            $display("FAIL bp_value got=%0d exp=2379", got);
        end
    endtask

    task automatic test_reset_abort;
        int t, wr_seen;
        int lat, got, got_g, wr_cnt, pops, bad_wr;
        @(negedge clock);
        real_in    = 32'd0;
        imag_in    = 32'hFFFF_FC00;
        real_empty = 1'b0;
        imag_empty = 1'b0;
        #1;
        t = 0;
        while (!real_rd_en && t < 100) begin
            @(negedge clock);
            #1;
            t++;
        end
        checks++;
        if (!real_rd_en) begin
            failures++;
            $display("FAIL abort_pop got=0 exp=1");
        end
        @(posedge clock);
        #1;
        real_empty = 1'b1;
        imag_empty = 1'b1;
        repeat (12) @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if (demod_out !== 32'd0 || g_demod_out !== 32'd0) begin
            failures++;
            $display("FAIL abort_demod_out got=%0d/%0d exp=0/0",
                     $signed(demod_out), $signed(g_demod_out));
        end
        wr_seen = 0;
        repeat (3) begin
            @(negedge clock);
            #1;
            if (out_wr_en) wr_seen++;
        end
        reset = 1'b0;
        repeat (40) begin
            @(negedge clock);
            #1;
            if (out_wr_en) wr_seen++;
        end
        checks++;
        if (wr_seen != 0) begin
            failures++;
            $display("FAIL abort_no_write got=%0d exp=0", wr_seen);
        end
        // prev must be back at (0,0): same result as the first sample.
        drive_sample(32'd1024, 32'd0, 0, lat, got, got_g, wr_cnt, pops, bad_wr);
        checks++;
        if (got != 1190 || lat != 36) begin
            failures++;
            $display("FAIL abort_next_sample got=%0d lat=%0d exp=1190 lat=36", got, lat);
        end
        checks++;
        if (got_g != EXP_G_FIRST) begin
            failures++;
            $display("FAIL abort_big_gain got=%0d exp=%0d", got_g, EXP_G_FIRST);
        end
    endtask

    initial begin
        test_reset();
        test_partial_empty();
        test_first_sample();
        test_phase_steps();
        test_backpressure();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
